// File: rtl/or_and_pkg.sv
// Shared types and helpers for the OR/AND exact-sum recovery unit.
package or_and_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter must be able to hold the value WIDTH itself (a full carry ripple).
   function automatic int iter_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/or_and_carry_step.sv
// One carry-propagation step of x+y: sum-without-carry, shifted carries, and the bit lost off the MSB.
module or_and_carry_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] x_nxt,
   output logic [WIDTH-1:0] y_nxt,
   output logic             msb_carry
);

   logic [WIDTH-1:0] gen;

   assign gen       = x & y;
   assign x_nxt     = x ^ y;
   assign y_nxt     = {gen[WIDTH-2:0], 1'b0};
   assign msb_carry = gen[WIDTH-1];

endmodule

// File: rtl/or_and_sum_recover.sv
// Rebuilds exact A+B (with carry-out) from (A|B) and (A&B) by iterative carry propagation.
// Optional feature: define OAR_ITER_COUNT_EN to add the out_iters port.
module or_and_sum_recover
   import or_and_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int MAX_ITER = WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_or,
   input  logic [WIDTH-1:0]            in_and,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WIDTH-1:0]            out_sum,
   output logic                        out_cout,
   output logic                        out_trunc
`ifdef OAR_ITER_COUNT_EN
   ,
   output logic [iter_w(WIDTH)-1:0]    out_iters
`endif
);

   localparam int IW = iter_w(WIDTH);
   localparam logic [IW-1:0] ITER_CAP = IW'(MAX_ITER);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             cout_q, cout_d;
   logic [IW-1:0]    iter_q, iter_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             ocout_q, ocout_d;
   logic             trunc_q, trunc_d;

   logic [WIDTH-1:0] x_step, y_step;
   logic             msb_carry;

   or_and_carry_step #(.WIDTH(WIDTH)) u_step (
      .x         (x_q),
      .y         (y_q),
      .x_nxt     (x_step),
      .y_nxt     (y_step),
      .msb_carry (msb_carry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         cout_q  <= 1'b0;
         iter_q  <= '0;
         sum_q   <= '0;
         ocout_q <= 1'b0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cout_q  <= cout_d;
         iter_q  <= iter_d;
         sum_q   <= sum_d;
         ocout_q <= ocout_d;
         trunc_q <= trunc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      cout_d  = cout_q;
      iter_d  = iter_q;
      sum_d   = sum_q;
      ocout_d = ocout_q;
      trunc_d = trunc_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = in_or;
               y_d     = in_and;
               cout_d  = 1'b0;
               iter_d  = '0;
               state_d = ITER;
            end
         end
         ITER: begin
            if (y_q == '0) begin
               sum_d   = x_q;
               ocout_d = cout_q;
               trunc_d = 1'b0;
               state_d = DONE;
            end else if (iter_q == ITER_CAP) begin
               // Unresolved carries are folded back in as OR: the best single-word approximation.
               sum_d   = x_q | y_q;
               ocout_d = cout_q;
               trunc_d = 1'b1;
               state_d = DONE;
            end else begin
               x_d    = x_step;
               y_d    = y_step;
               cout_d = cout_q | msb_carry;
               iter_d = iter_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_cout  = ocout_q;
   assign out_trunc = trunc_q;

`ifdef OAR_ITER_COUNT_EN
   logic [IW-1:0] iters_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         iters_q <= '0;
      end else if (state_q == ITER && state_d == DONE) begin
         iters_q <= iter_q;
      end
   end

   assign out_iters = iters_q;
`endif

`ifndef SYNTHESIS
   // The identity only holds when the AND word is a bit-subset of the OR word.
   always_ff @(posedge clk) begin
      if (!rst && in_valid && in_ready) begin
         assert ((in_and & ~in_or) == '0)
            else $error("or_and_sum_recover: in_and is not a subset of in_or");
      end
   end
`endif

endmodule
